// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared record type and lane count for the commit trace writer
package trace_pkg;

    localparam int TRACE_LANES = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo2w1r.sv
// rtl/trace_fifo2w1r.sv - two-write one-read first-word-fall-through record FIFO
module trace_fifo2w1r
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     we0,
    input  trace_rec_t               wd0,
    input  logic                     we1,
    input  trace_rec_t               wd1,
    input  logic                     re,
    output trace_rec_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t      mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_idx0, wr_idx1;
    logic            do_pop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count  = wr_ptr_q - rd_ptr_q;
    assign do_pop = re & ~empty;

    // Port 1 lands right after port 0 when both write, otherwise at the tail itself.
    assign wr_idx0 = wr_ptr_q[AW-1:0];
    assign wr_idx1 = wr_ptr_q[AW-1:0] + AW'(we0);

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(we0) + (AW+1)'(we1);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    // Empty reads return zero so the output fields match their reset values.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (we0) mem_q[wr_idx0] <= wd0;
        if (we1) mem_q[wr_idx1] <= wd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/commit_trace_writer.sv
// rtl/commit_trace_writer.sv - dual-lane commit capture into an ordered trace stream (optional TRACE_DROP_CNT_EN drop counter)
module commit_trace_writer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        trace_en,
    input  logic                        clr_ovf,
    input  logic [TRACE_LANES-1:0]      wb_valid,
    input  logic [TRACE_LANES*32-1:0]   wb_pc,
    input  logic [TRACE_LANES*5-1:0]    wb_rd,
    input  logic [TRACE_LANES*32-1:0]   wb_wdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_pc,
    output logic [4:0]                  out_wnum,
    output logic [31:0]                 out_wdata,
    output logic                        ovf,
    output logic [CNT_W-1:0]            drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t  rec0, rec1, wd0, wd1, head;
    logic        cand0, cand1;
    logic        we0, we1;
    logic        full, empty, pop;
    logic [AW:0] count, free;
    logic [1:0]  n_drop;
    logic        ovf_q, ovf_d;

    assign rec0  = '{pc: wb_pc[31:0],  wnum: wb_rd[4:0], wdata: wb_wdata[31:0]};
    assign rec1  = '{pc: wb_pc[63:32], wnum: wb_rd[9:5], wdata: wb_wdata[63:32]};
    assign cand0 = trace_en & wb_valid[0] & (wb_rd[4:0] != 5'd0);
    assign cand1 = trace_en & wb_valid[1] & (wb_rd[9:5] != 5'd0);

    // Space comes from the registered occupancy only; a same-cycle pop never helps.
    assign free = full ? '0 : (AW+1)'(DEPTH) - count;

    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        wd0    = rec0;
        wd1    = rec1;
        n_drop = 2'd0;
        if (cand0 && cand1) begin
            we0    = (free != '0);
            we1    = (free >= (AW+1)'(2));
            n_drop = (free == '0) ? 2'd2 : (free == (AW+1)'(1)) ? 2'd1 : 2'd0;
        end else if (cand0 || cand1) begin
            wd0    = cand0 ? rec0 : rec1;
            we0    = (free != '0);
            n_drop = (free == '0) ? 2'd1 : 2'd0;
        end
    end

    trace_fifo2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .we0    (we0),
        .wd0    (wd0),
        .we1    (we1),
        .wd1    (wd1),
        .re     (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign out_pc    = head.pc;
    assign out_wnum  = head.wnum;
    assign out_wdata = head.wdata;

    // A drop in the same cycle as a clear keeps the flag set.
    assign ovf_d = (n_drop != 2'd0) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    assign ovf   = ovf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

`ifdef TRACE_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]   drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
        if (clr_ovf)              drop_cnt_d = CNT_W'(n_drop);
        else if (drop_sum[CNT_W]) drop_cnt_d = '1;
        else                      drop_cnt_d = drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_commit_trace_writer.sv
// tb/tb_commit_trace_writer.sv - randomized self-checking bench for commit_trace_writer against a queue model
module tb_commit_trace_writer;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              trace_en = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [1:0]        wb_valid = '0;
    logic [63:0]       wb_pc = '0;
    logic [9:0]        wb_rd = '0;
    logic [63:0]       wb_wdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [4:0]        out_wnum;
    logic [31:0]       out_wdata;
    logic              ovf;
    logic [CNT_W-1:0]  drop_cnt;

    commit_trace_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .trace_en  (trace_en),
        .clr_ovf   (clr_ovf),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .wb_rd     (wb_rd),
        .wb_wdata  (wb_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_wnum  (out_wnum),
        .out_wdata (out_wdata),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    trace_rec_t mq[$];
    logic       m_ovf = 1'b0;
    longint     m_dcnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [1:0] v, input logic [31:0] p0, input logic [4:0] r0,
                          input logic [31:0] p1, input logic [4:0] r1, input logic rdy);
        wb_valid  = v;
        wb_pc     = {p1, p0};
        wb_rd     = {r1, r0};
        wb_wdata  = {$urandom(), $urandom()};
        out_ready = rdy;
    endtask

    // Check outputs against the model, then advance the model by one clock.
    task automatic step();
        trace_rec_t head, rec;
        trace_rec_t pushed[$];
        int         free, drops;
        logic [4:0] rd_l;
        @(negedge clk);
        head = (mq.size() != 0) ? mq[0] : '0;
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("out_pc",    64'(out_pc),    64'(head.pc));
        check("out_wnum",  64'(out_wnum),  64'(head.wnum));
        check("out_wdata", 64'(out_wdata), 64'(head.wdata));
        check("ovf",       64'(ovf),       64'(m_ovf));
        check("count",     64'(dut.u_fifo.count), 64'(mq.size()));
`ifdef TRACE_DROP_CNT_EN
        check("drop_cnt",  64'(drop_cnt),  64'(m_dcnt));
`else
        check("drop_cnt",  64'(drop_cnt),  64'(0));
`endif
        free  = DEPTH - mq.size();
        drops = 0;
        for (int l = 0; l < 2; l++) begin
            rd_l = wb_rd[5*l +: 5];
            if (trace_en && wb_valid[l] && rd_l != 0) begin
                rec = '{pc: wb_pc[32*l +: 32], wnum: rd_l, wdata: wb_wdata[32*l +: 32]};
                if (free > 0) begin
                    pushed.push_back(rec);
                    free--;
                end else begin
                    drops++;
                end
            end
        end
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        foreach (pushed[k]) mq.push_back(pushed[k]);
        if (drops != 0)   m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (clr_ovf) m_dcnt = drops;
        else         m_dcnt = (m_dcnt + drops > 65535) ? 65535 : m_dcnt + drops;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        set_in(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, rdy);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(2'b01, 32'h1000 + 32'(i * 4), 5'(1 + (i % 31)), 32'h0, 5'd0, 1'b0);
            step();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            idle(1'b1);
            step();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        trace_en = 1'b1;

        idle(1'b0); step();
        // single lane0 commit, visible one cycle later
        set_in(2'b01, 32'hbfc00000, 5'd2, 32'h0, 5'd0, 1'b0);
        wb_wdata = 64'h1234;
        step();
        idle(1'b0); step(); step();
        drain();

        // dual commit in order
        set_in(2'b11, 32'hA0, 5'd3, 32'hA4, 5'd4, 1'b1); step();
        idle(1'b1); step(); step(); step();

        // rd=0 on lane0 is skipped
        set_in(2'b11, 32'hB0, 5'd0, 32'hB4, 5'd5, 1'b1); step();
        idle(1'b1); step(); step();

        // full FIFO then dual commit drops both; drain while checking stall stability
        fill(DEPTH);
        set_in(2'b11, 32'hC0, 5'd6, 32'hC4, 5'd7, 1'b0); step();
        idle(1'b0); step(); step();
        drain();
        clr_ovf = 1'b1; idle(1'b0); step(); clr_ovf = 1'b0;

        // count=15 with pop: lane0 stored, lane1 dropped
        fill(DEPTH - 1);
        set_in(2'b11, 32'hD0, 5'd8, 32'hD4, 5'd9, 1'b1); step();
        idle(1'b0); step();
        drain();

        // capture disabled
        trace_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(2'b11, $urandom(), 5'd10, $urandom(), 5'd11, 1'b0); step();
        end
        trace_en = 1'b1;

        // clear together with a drop keeps ovf set
        fill(DEPTH);
        clr_ovf = 1'b1;
        set_in(2'b11, 32'hE0, 5'd12, 32'hE4, 5'd13, 1'b0); step();
        clr_ovf = 1'b0;
        idle(1'b1); step(); step(); step();

        // asynchronous reset mid-drain
        resetn = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));
        check("rst_out_pc",    64'(out_pc),    64'(0));
        mq.delete();
        m_ovf  = 1'b0;
        m_dcnt = 0;
        @(posedge clk);
        #1 resetn = 1'b1;
        idle(1'b0); step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            trace_en = ($urandom_range(0, 15) != 0);
            clr_ovf  = ($urandom_range(0, 31) == 0);
            set_in(2'($urandom()), $urandom(), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                   $urandom(), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                   ($urandom_range(0, 2) == 0));
            step();
        end
        clr_ovf = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
